sequential_multiplier: RTL and testbench
========================================

# sequential_multiplier

Parametrised shift-add multiplier, the successor to the fixed 4-bit datapath multiplier. It computes a full 2·WIDTH-bit product of two WIDTH-bit operands, one partial product per clock. It adds a per-operation signed/unsigned mode, a Busy/Done handshake, and back-to-back operation. It sits in the data unit as a multi-cycle arithmetic resource driven by the controller.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32; product is 2·WIDTH bits
- Clock  input  1  rising-edge clock, the only clock domain
- Reset  input  1  synchronous, active-low; sampled on the rising edge of Clock
- Start  input  1  request a new multiplication; level-sensitive; honoured only when Busy=0
- Signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with Start
- Multiplicand  input  WIDTH  operand A; sampled with Start
- Multiplier  input  WIDTH  operand B; sampled with Start
- Product  output  2·WIDTH  result register; holds the last completed result
- Busy  output  1  high while an operation is in progress
- Done  output  1  one-cycle pulse when Product has been updated with a new result

## Operation
- Reset (Reset=0 at an edge) has the following effects:
  - state goes to IDLE
  - Product=0, Busy=0, Done=0
  - internal accumulator, counter and sign flag are cleared
  - Reset overrides Start.
- **IDLE**: Busy=0. On an edge with Start=1:
  - latch the operand magnitudes into A_mag and B_mag. When Signed=1 and an operand's MSB is 1, the magnitude is its two's-complement negation, taken as an unsigned WIDTH-bit value. −2^(WIDTH−1) therefore maps to 2^(WIDTH−1).
  - latch neg = Signed & (A_MSB ^ B_MSB)
  - clear the 2·WIDTH-bit accumulator; load counter = WIDTH
  - go to CALC.
- **CALC**: Busy=1. Each edge performs one step:
  - if the LSB of B_mag is 1, add A_mag (zero-extended, shifted left by the step index) to the accumulator
  - shift B_mag right by 1 and decrement the counter.
  - After WIDTH edges, go to FIX.
- **FIX**: Busy=1. One edge:
  - write Product = neg ? −accumulator (2·WIDTH-bit two's complement) : accumulator
  - set Done=1 for the following cycle
  - return to IDLE.
- Product changes only on the FIX edge or on reset. Partial sums are never visible on Product.
- A zero operand still takes the full latency and yields Product=0 with Done. No early termination.
- Arithmetic is exact for every operand pair in both modes. Overflow is impossible because a 2·WIDTH-bit result covers both ranges, e.g. (−2^(W−1))² = 2^(2W−2).
- Start, Signed and operand changes while Busy=1 are ignored. Operands need not be held after the accepting edge.

## Timing
- Accepting edge = edge 0. Busy is high from after edge 0 through edge W+1.
- Product is updated, Done=1 and Busy=0, all in the cycle after edge W+1.
- Latency from the Start edge to Done: W+1 clocks (W=8: 9).
- Done is high for exactly one cycle. The state is already IDLE during that cycle.
- Start=1 during the Done cycle is accepted. Holding Start high therefore repeats operations every W+2 cycles with no idle gap, re-sampling the operands each time.
- Reset asserted during CALC or FIX aborts the operation:
  - no Done pulse
  - Product=0 on the next cycle
  - Start is accepted on the first edge with Reset=1.
- The Start and Reset pair both sampled on the same edge: Reset wins and Start is dropped.

## Test plan
- **Unsigned small width.** WIDTH=4, Signed=0, 13×13. Expect Product=169 (0xA9) and a one-cycle Done, 5 clocks after the Start edge.
- **Unsigned back-to-back.** WIDTH=4, Signed=0, 9×11, 2×2, 5×8, 3×14 with Start held high. Expect Products 99, 4, 40, 42 in that order, Done pulses exactly 6 cycles apart, and Busy low only in the Done cycles.
- **Signed extremes.** WIDTH=8, Signed=1:
  - −3×5 → 0xFFF1
  - −128×−128 → 0x4000
  - −128×127 → 0xC080
  - 0×−1 → 0x0000
  - Rerun 0xFF×0xFF with Signed=0 → 0xFE01.
- **Busy protection.** WIDTH=8, 200×3 accepted. At edge 3, present Start=1 with operands 7×7. Expect Product=600 with exactly one Done, and Busy=0 only after that Done.
- **Reset mid-operation.** WIDTH=8, start 100×100 and drop Reset at edge 4. Expect Product=0, Busy=0, and no Done pulse. Start 10×10 after release; expect Product=100 after 9 clocks.
- **Randomised sweep.** WIDTH=8, 1000 random pairs in both modes. Check against a reference model and assert the Done spacing.

Source files
------------

// File: rtl/sequential_multiplier.sv
// Shift-add multiplier: one partial product per clock, full 2*WIDTH-bit product,
// per-operation signed/unsigned mode with Busy/Done handshake.
module sequential_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Signed,
    input  logic [WIDTH-1:0]     Multiplicand,
    input  logic [WIDTH-1:0]     Multiplier,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 Busy,
    output logic                 Done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]     b_mag;
    logic [CW-1:0]        count;
    logic                 neg;

    // Negative two's-complement operands become their unsigned magnitude, so
    // the most negative value maps to 2^(WIDTH-1) without overflow.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic s);
        return (s && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] v);
        return ~v + (2*WIDTH)'(1);
    endfunction

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state   <= IDLE;
            Product <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            acc     <= '0;
            a_sh    <= '0;
            b_mag   <= '0;
            count   <= '0;
            neg     <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        a_sh  <= {{WIDTH{1'b0}}, magnitude(Multiplicand, Signed)};
                        b_mag <= magnitude(Multiplier, Signed);
                        neg   <= Signed & (Multiplicand[WIDTH-1] ^ Multiplier[WIDTH-1]);
                        acc   <= '0;
                        count <= CW'(WIDTH);
                        Busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                // a_sh carries A_mag already shifted by the current step index.
                CALC: begin
                    if (b_mag[0]) begin
                        acc <= acc + a_sh;
                    end
                    a_sh  <= a_sh << 1;
                    b_mag <= b_mag >> 1;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    Product <= neg ? negate(acc) : acc;
                    Done    <= 1'b1;
                    Busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequential_multiplier.sv
// Bench for sequential_multiplier: WIDTH=4 and WIDTH=8 instances, scoreboard
// queues popped on Done, table of signed/unsigned corner vectors plus sequences.
module tb_sequential_multiplier;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    logic        rst4, st4, sg4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;
    logic        busy4, done4;

    logic        rst8, st8, sg8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic        busy8, done8;

    logic [7:0]  q4[$];
    logic [15:0] q8[$];
    logic [7:0]  prev4 = '0;
    logic [15:0] prev8 = '0;
    logic        rst4_q = 1'b0;
    logic        rst8_q = 1'b0;
    int          done_cnt8 = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        bit          s;
        logic [15:0] exp;
    } vec_t;

    sequential_multiplier #(.WIDTH(4)) dut4 (
        .Clock(clk), .Reset(rst4), .Start(st4), .Signed(sg4),
        .Multiplicand(a4), .Multiplier(b4),
        .Product(p4), .Busy(busy4), .Done(done4)
    );

    sequential_multiplier #(.WIDTH(8)) dut8 (
        .Clock(clk), .Reset(rst8), .Start(st8), .Signed(sg8),
        .Multiplicand(a8), .Multiplier(b8),
        .Product(p8), .Busy(busy8), .Done(done8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rst4_q <= rst4;
        rst8_q <= rst8;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input bit s);
        int sa, sb;
        sa = s ? int'($signed(a)) : int'(a);
        sb = s ? int'($signed(b)) : int'(b);
        return 16'(sa * sb);
    endfunction

    // Scoreboards: pop on Done, otherwise Product must hold its value.
    always @(negedge clk) begin
        if (done4) begin
            check("dut4 scoreboard nonempty at done", 64'(q4.size() != 0), 64'd1);
            if (q4.size() != 0) check("dut4 product", 64'(p4), 64'(q4.pop_front()));
        end else if (rst4_q) begin
            check("dut4 product stable", 64'(p4), 64'(prev4));
        end
        prev4 = p4;
    end

    always @(negedge clk) begin
        if (done8) begin
            done_cnt8++;
            check("dut8 scoreboard nonempty at done", 64'(q8.size() != 0), 64'd1);
            if (q8.size() != 0) check("dut8 product", 64'(p8), 64'(q8.pop_front()));
        end else if (rst8_q) begin
            check("dut8 product stable", 64'(p8), 64'(prev8));
        end
        prev8 = p8;
    end

    task automatic wait_idle4();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy4) return;
        end
        check("dut4 idle timeout", 64'(busy4), 64'd0);
    endtask

    task automatic wait_idle8();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy8) return;
        end
        check("dut8 idle timeout", 64'(busy8), 64'd0);
    endtask

    // Called at a negedge; Start is seen on the next rising edge.
    task automatic go4(input logic [3:0] a, input logic [3:0] b, input bit s,
                       input logic [7:0] exp, output int c0);
        st4 = 1'b1; a4 = a; b4 = b; sg4 = s; c0 = cyc;
        q4.push_back(exp);
        @(negedge clk);
        st4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); sg4 = 1'($urandom);
    endtask

    task automatic go8(input logic [7:0] a, input logic [7:0] b, input bit s,
                       input bit push, input logic [15:0] exp, output int c0);
        st8 = 1'b1; a8 = a; b8 = b; sg8 = s; c0 = cyc;
        if (push) q8.push_back(exp);
        @(negedge clk);
        st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sg8 = 1'($urandom);
    endtask

    task automatic wait_done4(output int dcyc, output bit bok);
        bok = 1'b1; dcyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done4) begin dcyc = cyc; return; end
            if (!busy4) bok = 1'b0;
        end
        check("dut4 done timeout", 64'(done4), 64'd1);
    endtask

    task automatic wait_done8(output int dcyc, output bit bok);
        bok = 1'b1; dcyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done8) begin dcyc = cyc; return; end
            if (!busy8) bok = 1'b0;
        end
        check("dut8 done timeout", 64'(done8), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[9];
        int          c0, dcyc, dprev, dc;
        bit          bok;
        logic [3:0]  ba[4] = '{4'd9, 4'd2, 4'd5, 4'd3};
        logic [3:0]  bb[4] = '{4'd11, 4'd2, 4'd8, 4'd14};
        logic [7:0]  be[4] = '{8'd99, 8'd4, 8'd40, 8'd42};

        tbl[0] = '{8'hFD, 8'h05, 1'b1, 16'hFFF1};
        tbl[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
        tbl[2] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        tbl[3] = '{8'h00, 8'hFF, 1'b1, 16'h0000};
        tbl[4] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        tbl[5] = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
        tbl[6] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
        tbl[7] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        tbl[8] = '{8'h00, 8'h00, 1'b0, 16'h0000};

        // Reset, with Start asserted on the 8-bit unit to show Reset wins.
        rst4 = 1'b0; st4 = 1'b0; sg4 = 1'b0; a4 = '0; b4 = '0;
        rst8 = 1'b0; st8 = 1'b1; sg8 = 1'b0; a8 = 8'd5; b8 = 8'd6;
        repeat (3) @(negedge clk);
        check("reset dut4 product", 64'(p4), 64'd0);
        check("reset dut4 busy", 64'(busy4), 64'd0);
        check("reset dut4 done", 64'(done4), 64'd0);
        check("reset dut8 product", 64'(p8), 64'd0);
        check("reset dut8 busy with start", 64'(busy8), 64'd0);
        check("reset dut8 done", 64'(done8), 64'd0);
        rst4 = 1'b1; rst8 = 1'b1; st8 = 1'b0;

        // WIDTH=4 single unsigned operation.
        wait_idle4();
        go4(4'd13, 4'd13, 1'b0, 8'hA9, c0);
        wait_done4(dcyc, bok);
        check("w4 13x13 latency", 64'(dcyc - c0), 64'd6);
        check("w4 13x13 busy held", 64'(bok), 64'd1);
        @(negedge clk);
        check("w4 done one cycle", 64'(done4), 64'd0);

        // WIDTH=4 back-to-back with Start held high.
        st4 = 1'b1; sg4 = 1'b0; a4 = ba[0]; b4 = bb[0];
        q4.push_back(be[0]);
        dprev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_done4(dcyc, bok);
            check("w4 b2b busy between dones", 64'(bok), 64'd1);
            check("w4 b2b busy low in done cycle", 64'(busy4), 64'd0);
            if (k > 0) check("w4 b2b done spacing", 64'(dcyc - dprev), 64'd6);
            dprev = dcyc;
            if (k < 3) begin
                a4 = ba[k+1]; b4 = bb[k+1];
                q4.push_back(be[k+1]);
            end else begin
                st4 = 1'b0;
            end
        end

        // WIDTH=8 table of signed/unsigned corner vectors.
        foreach (tbl[i]) begin
            wait_idle8();
            go8(tbl[i].a, tbl[i].b, tbl[i].s, 1'b1, tbl[i].exp, c0);
            wait_done8(dcyc, bok);
            check("w8 table latency", 64'(dcyc - c0), 64'd10);
            check("w8 table busy held", 64'(bok), 64'd1);
        end

        // Start with new operands while busy must be ignored.
        wait_idle8();
        dc = done_cnt8;
        go8(8'd200, 8'd3, 1'b0, 1'b1, 16'd600, c0);
        @(negedge clk);
        @(negedge clk);
        st8 = 1'b1; a8 = 8'd7; b8 = 8'd7; sg8 = 1'b0;
        @(negedge clk);
        st8 = 1'b0;
        check("busy-protect busy at edge 3", 64'(busy8), 64'd1);
        wait_done8(dcyc, bok);
        check("busy-protect latency", 64'(dcyc - c0), 64'd10);
        check("busy-protect busy held", 64'(bok), 64'd1);
        repeat (12) @(negedge clk);
        check("busy-protect single done", 64'(done_cnt8 - dc), 64'd1);
        check("busy-protect idle afterwards", 64'(busy8), 64'd0);

        // Reset at edge 4 of an operation aborts it.
        wait_idle8();
        dc = done_cnt8;
        go8(8'd100, 8'd100, 1'b0, 1'b0, 16'd0, c0);
        repeat (3) @(negedge clk);
        rst8 = 1'b0;
        @(negedge clk);
        check("abort product cleared", 64'(p8), 64'd0);
        check("abort busy low", 64'(busy8), 64'd0);
        check("abort no done", 64'(done8), 64'd0);
        rst8 = 1'b1;
        go8(8'd10, 8'd10, 1'b0, 1'b1, 16'd100, c0);
        wait_done8(dcyc, bok);
        check("post-abort latency", 64'(dcyc - c0), 64'd10);
        repeat (3) @(negedge clk);
        check("post-abort single done", 64'(done_cnt8 - dc), 64'd1);

        // Randomised back-to-back sweep, both modes.
        wait_idle8();
        st8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); sg8 = 1'($urandom);
        q8.push_back(ref8(a8, b8, sg8));
        dprev = 0;
        for (int k = 0; k < 1000; k++) begin
            wait_done8(dcyc, bok);
            check("rand busy between dones", 64'(bok), 64'd1);
            if (k > 0) check("rand done spacing", 64'(dcyc - dprev), 64'd10);
            dprev = dcyc;
            if (k < 999) begin
                a8 = 8'($urandom); b8 = 8'($urandom); sg8 = 1'($urandom);
                q8.push_back(ref8(a8, b8, sg8));
            end else begin
                st8 = 1'b0;
            end
        end

        repeat (15) @(negedge clk);
        check("dut4 scoreboard drained", 64'(q4.size()), 64'd0);
        check("dut8 scoreboard drained", 64'(q8.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
